// File: rtl/method_call_pkg.sv
// rtl/method_call_pkg.sv - shared types and defaults for the method call sequencer
// Purpose : FSM state encoding, default widths and watchdog limit, saturating counter helper.
// Ports   : none (package).
// Config  : CALL_TIMEOUT_EN is consumed by method_call_sequencer, not here.
package method_call_pkg;

    localparam int DEF_RET_W   = 32;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_ACC_W   = 40;
    localparam int DEF_TMO_CYC = 255;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_RUN  = 3'd2,
        ST_CAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Cycle counter sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/method_call_sequencer_if.sv
// rtl/method_call_sequencer_if.sv - req/busy/return handshake to one callee method
// Purpose : bundles the call request, callee busy and callee return value.
// Signals : o_main_req (caller->callee), i_main_busy (callee->caller),
//           i_main_return[RET_W] (callee->caller, valid when busy falls).
// Modports: master = caller side, slave = callee side.
interface method_call_sequencer_if
    import method_call_pkg::*;
#(
    parameter int RET_W = DEF_RET_W
) ();

    logic             o_main_req;
    logic             i_main_busy;
    logic [RET_W-1:0] i_main_return;

    modport master (
        output o_main_req,
        input  i_main_busy,
        input  i_main_return
    );

    modport slave (
        input  o_main_req,
        output i_main_busy,
        output i_main_return
    );

endinterface

// File: rtl/method_call_watchdog.sv
// rtl/method_call_watchdog.sv - per-wait-state timeout counter
// Purpose : counts clock-enabled cycles while enabled; o_expire flags the TMO_CYC-th cycle.
// Ports   : clock, reset_n (async active-low), ce (clock enable),
//           i_clear (restart count), i_enable (count this cycle), o_expire (limit reached).
module method_call_watchdog
    import method_call_pkg::*;
#(
    parameter int TMO_CYC = DEF_TMO_CYC
) (
    input  logic clock,
    input  logic reset_n,
    input  logic ce,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = $clog2(TMO_CYC + 1);

    logic [CW-1:0] r_count;

    // Expire is combinational so the FSM leaves on exactly the TMO_CYC-th waiting cycle.
    assign o_expire = i_enable && (r_count == CW'(TMO_CYC - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (ce) begin
            if (i_clear) begin
                r_count <= '0;
            end else if (i_enable && !o_expire) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/method_call_sequencer.sv
// rtl/method_call_sequencer.sv - batch caller for a generated-method req/busy/return handshake
// Purpose : issues i_count back-to-back calls per accepted start, accumulates signed returns,
//           reports last return and batch cycle count.
// Ports   : clock, reset_n (async active-low), ce (clock enable, low freezes everything),
//           i_start/i_count (host start, sampled in IDLE), o_busy, o_done (pulse), o_error,
//           o_acc[ACC_W], o_last[RET_W], o_cycles[32], bus (master side of the call handshake).
// Config  : CALL_TIMEOUT_EN adds a watchdog in REQ/RUN that aborts the batch with o_error.
module method_call_sequencer
    import method_call_pkg::*;
#(
    parameter int RET_W   = DEF_RET_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int TMO_CYC = DEF_TMO_CYC
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 ce,
    input  logic                 i_start,
    input  logic [CNT_W-1:0]     i_count,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    output logic [ACC_W-1:0]     o_acc,
    output logic [RET_W-1:0]     o_last,
    output logic [31:0]          o_cycles,
    method_call_sequencer_if.master bus
);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_remaining;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic               r_req;
    logic [ACC_W-1:0]   r_acc;
    logic [RET_W-1:0]   r_last;
    logic [31:0]        r_cycles;
    logic               w_expire;

`ifdef CALL_TIMEOUT_EN
    logic w_wd_clear;
    logic w_wd_enable;

    // Restarting on any state change gives each REQ and RUN visit a fresh budget.
    assign w_wd_clear  = (w_next != r_state);
    assign w_wd_enable = (r_state == ST_REQ) || (r_state == ST_RUN);

    method_call_watchdog #(
        .TMO_CYC (TMO_CYC)
    ) u_watchdog (
        .clock    (clock),
        .reset_n  (reset_n),
        .ce       (ce),
        .i_clear  (w_wd_clear),
        .i_enable (w_wd_enable),
        .o_expire (w_expire)
    );
`else
    logic w_unused_tmo;

    assign w_unused_tmo = (TMO_CYC > 0);
    assign w_expire     = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else if (ce) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next = (i_count == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_expire) begin
                    w_next = ST_DONE;
                end else if (bus.i_main_busy) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_expire) begin
                    w_next = ST_DONE;
                end else if (!bus.i_main_busy) begin
                    w_next = ST_CAP;
                end
            end
            ST_CAP: begin
                w_next = (r_remaining == CNT_W'(1)) ? ST_DONE : ST_REQ;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_req       <= 1'b0;
            r_acc       <= '0;
            r_last      <= '0;
            r_cycles    <= '0;
        end else if (ce) begin
            r_done <= 1'b0;
            // Request is a registered image of "next state is REQ", so it rises on entry
            // and drops on the edge that leaves REQ (busy seen or watchdog abort).
            r_req  <= (w_next == ST_REQ);
            if (r_state != ST_IDLE) begin
                r_cycles <= sat_inc32(r_cycles);
            end
            unique case (r_state)
                ST_IDLE: begin
                    r_busy <= i_start;
                    if (i_start) begin
                        r_acc       <= '0;
                        r_last      <= '0;
                        r_error     <= 1'b0;
                        r_cycles    <= 32'd1;
                        r_remaining <= i_count;
                    end
                end
                ST_REQ, ST_RUN: begin
                    if (w_expire) begin
                        r_error <= 1'b1;
                    end
                end
                ST_CAP: begin
                    r_last      <= bus.i_main_return;
                    r_acc       <= r_acc + ACC_W'($signed(bus.i_main_return));
                    r_remaining <= r_remaining - 1'b1;
                end
                ST_DONE: begin
                    r_done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_error        = r_error;
    assign o_acc          = r_acc;
    assign o_last         = r_last;
    assign o_cycles       = r_cycles;
    assign bus.o_main_req = r_req;

endmodule

// File: tb/tb_method_call_sequencer.sv
// tb/tb_method_call_sequencer.sv - self-checking bench for method_call_sequencer
`timescale 1ns/1ps
module tb_method_call_sequencer;
    import method_call_pkg::*;

    localparam int RET_W = 32;
    localparam int CNT_W = 8;
    localparam int ACC_W = 40;
`ifdef CALL_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic             clock   = 1'b0;
    logic             reset_n = 1'b0;
    logic             ce      = 1'b1;
    logic             i_start = 1'b0;
    logic [CNT_W-1:0] i_count = '0;
    logic             o_busy;
    logic             o_done;
    logic             o_error;
    logic [ACC_W-1:0] o_acc;
    logic [RET_W-1:0] o_last;
    logic [31:0]      o_cycles;

    int checks   = 0;
    int failures = 0;

    method_call_sequencer_if #(.RET_W(RET_W)) bus ();

    method_call_sequencer #(
        .RET_W   (RET_W),
        .CNT_W   (CNT_W),
        .ACC_W   (ACC_W),
        .TMO_CYC (TMO)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .ce       (ce),
        .i_start  (i_start),
        .i_count  (i_count),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_error  (o_error),
        .o_acc    (o_acc),
        .o_last   (o_last),
        .o_cycles (o_cycles),
        .bus      (bus)
    );

    always #5 clock = ~clock;

    // Callee stub: samples req while idle, busy from next cycle for call_len cycles.
    logic [31:0] call_ret [256];
    int          call_len [256];
    bit          stub_dead = 1'b0;
    int          s_idx = 0;
    int          s_rem = 0;
    logic        s_busy = 1'b0;
    logic [31:0] s_ret = '0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_busy <= 1'b0;
            s_rem  <= 0;
        end else if (ce) begin
            if (s_busy) begin
                if (s_rem <= 1) s_busy <= 1'b0;
                else            s_rem  <= s_rem - 1;
            end else if (bus.o_main_req && !stub_dead) begin
                s_busy <= 1'b1;
                s_rem  <= call_len[s_idx % 256];
                s_ret  <= call_ret[s_idx % 256];
                s_idx  <= s_idx + 1;
            end
        end
    end

    assign bus.i_main_busy   = s_busy;
    assign bus.i_main_return = s_ret;

    // Event monitor sampled mid-cycle.
    int   req_hi    = 0;
    int   req_rise  = 0;
    int   done_rise = 0;
    logic prev_req  = 1'b0;
    logic prev_done = 1'b0;

    always @(negedge clock) begin
        if (ce && bus.o_main_req)             req_hi    <= req_hi + 1;
        if (bus.o_main_req && !prev_req)      req_rise  <= req_rise + 1;
        if (o_done && !prev_done)             done_rise <= done_rise + 1;
        prev_req  <= bus.o_main_req;
        prev_done <= o_done;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_batch(input int k);
        @(negedge clock);
        i_start = 1'b1;
        i_count = CNT_W'(k);
        @(negedge clock);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        for (int n = 0; n < 3000; n++) begin
            if (o_done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
            waited++;
        end
        check({tag, "_done_seen"}, 64'(ok), 64'd1);
    endtask

    // Reference model: each call costs 2 REQ cycles + busy length + 1 CAP cycle;
    // the batch adds one start cycle and one DONE cycle.
    task automatic run_batch(input string tag, input int k, input bit rnd,
                             input logic [31:0] fixed_ret, input int fixed_len,
                             input bit mid_start);
        longint      sum;
        logic [39:0] exp_acc;
        logic [31:0] exp_last;
        logic [31:0] r;
        int          exp_cyc, base, l, waited, req0, rise0, done0;
        sum      = 0;
        exp_cyc  = 2;
        exp_last = '0;
        base     = s_idx;
        for (int i = 0; i < k; i++) begin
            r = rnd ? 32'($urandom) : fixed_ret;
            l = rnd ? int'($urandom_range(1, 5)) : fixed_len;
            call_ret[(base + i) % 256] = r;
            call_len[(base + i) % 256] = l;
            sum      += longint'($signed(r));
            exp_cyc  += l + 3;
            exp_last  = r;
        end
        exp_acc = sum[39:0];
        req0  = req_hi;
        rise0 = req_rise;
        done0 = done_rise;
        start_batch(k);
        if (mid_start) begin
            repeat (3) @(negedge clock);
            i_start = 1'b1;
            i_count = CNT_W'(7);
            @(negedge clock);
            i_start = 1'b0;
        end
        wait_done(tag, waited);
        if (k == 0) check({tag, "_done_latency"}, 64'(waited), 64'd1);
        check({tag, "_busy_at_done"}, 64'(o_busy),   64'd1);
        check({tag, "_acc"},          64'(o_acc),    64'(exp_acc));
        check({tag, "_last"},         64'(o_last),   64'(exp_last));
        check({tag, "_cycles"},       64'(o_cycles), 64'(exp_cyc));
        check({tag, "_error"},        64'(o_error),  64'd0);
        @(negedge clock);
        #1;
        check({tag, "_done_pulse"}, 64'(o_done), 64'd0);
        check({tag, "_busy_end"},   64'(o_busy), 64'd0);
        check({tag, "_req_cycles"}, 64'(req_hi - req0),      64'(2 * k));
        check({tag, "_req_pulses"}, 64'(req_rise - rise0),   64'(k));
        check({tag, "_done_count"}, 64'(done_rise - done0),  64'd1);
    endtask

    initial begin
        int waited;
        logic [31:0] frozen;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_busy",   64'(o_busy),         64'd0);
        check("rst_done",   64'(o_done),         64'd0);
        check("rst_error",  64'(o_error),        64'd0);
        check("rst_acc",    64'(o_acc),          64'd0);
        check("rst_last",   64'(o_last),         64'd0);
        check("rst_cycles", 64'(o_cycles),       64'd0);
        check("rst_req",    64'(bus.o_main_req), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Directed cases
        run_batch("single",  1, 1'b0, 32'd2290, 6, 1'b0);
        run_batch("triple",  3, 1'b0, 32'd2290, 6, 1'b0);
        run_batch("zero",    0, 1'b0, 32'd2290, 6, 1'b0);
        run_batch("neg",     2, 1'b0, -32'sd5,  6, 1'b1);

`ifdef CALL_TIMEOUT_EN
        begin
            int req0;
            req0 = req_hi;
            stub_dead = 1'b1;
            start_batch(2);
            wait_done("tmo", waited);
            check("tmo_error",  64'(o_error),        64'd1);
            check("tmo_req",    64'(bus.o_main_req), 64'd0);
            check("tmo_cycles", 64'(o_cycles),       64'(TMO + 2));
            check("tmo_acc",    64'(o_acc),          64'd0);
            @(negedge clock);
            #1;
            check("tmo_req_cycles", 64'(req_hi - req0), 64'(TMO));
            check("tmo_error_held", 64'(o_error),       64'd1);
            stub_dead = 1'b0;
        end
`endif

        // Randomized batches
        for (int b = 0; b < 5; b++) begin
            run_batch($sformatf("rnd%0d", b), int'($urandom_range(1, 6)), 1'b1, '0, 1, 1'b0);
        end

        // ce freeze mid-RUN
        call_ret[s_idx % 256] = 32'd2290;
        call_len[s_idx % 256] = 6;
        start_batch(1);
        repeat (3) @(negedge clock);
        frozen = o_cycles;
        ce = 1'b0;
        repeat (4) @(negedge clock);
        check("ce_cycles_frozen", 64'(o_cycles), 64'(frozen));
        check("ce_busy_held",     64'(o_busy),   64'd1);
        ce = 1'b1;
        wait_done("ce", waited);
        check("ce_cycles", 64'(o_cycles), 64'd11);
        check("ce_acc",    64'(o_acc),    64'd2290);
        repeat (2) @(negedge clock);

        // Async reset mid-REQ
        call_ret[s_idx % 256] = 32'd2290;
        call_len[s_idx % 256] = 6;
        start_batch(2);
        check("mid_req_high", 64'(bus.o_main_req), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_req",    64'(bus.o_main_req), 64'd0);
        check("arst_busy",   64'(o_busy),         64'd0);
        check("arst_cycles", 64'(o_cycles),       64'd0);
        check("arst_acc",    64'(o_acc),          64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        run_batch("post_rst", 1, 1'b0, 32'd77, 3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
